// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the writable program memory: opcodes, fixed
// instruction words, loader FSM states and the bytes-per-word derivation.
package prog_mem_loader_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LED = 4'h7;

  localparam int PKG_INSTR_WIDTH = 28;

  localparam logic [PKG_INSTR_WIDTH-1:0] PKG_NOP_INSTR     = {OP_NOP, 24'd0};
  localparam logic [PKG_INSTR_WIDTH-1:0] PKG_DEFAULT_INSTR = {OP_LED, 24'b10101010};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } load_state_e;

  // Loader bytes needed to cover one instruction word.
  function automatic int bytes_per_word(input int instr_width);
    return (instr_width + 7) / 8;
  endfunction

endpackage

// File: rtl/prog_mem_loader_byte_word_assembler.sv
// Collects an MSB-first byte stream into instruction words and strobes
// word_done in the cycle the last byte of a word is accepted.
module prog_mem_loader_byte_word_assembler #(
  parameter int INSTR_WIDTH    = 28,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             data,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_done,
  output logic                   pending
);

  localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [CNT_W-1:0]       cnt;
  logic [INSTR_WIDTH-1:0] sh;
  logic [INSTR_WIDTH-1:0] nxt;
  logic                   last;

  // Bits shifted past the word width fall off, which drops the unused
  // upper bits of the first byte.
  assign nxt       = INSTR_WIDTH'({sh, data});
  assign last      = (cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign word      = nxt;
  assign word_done = accept && last;
  assign pending   = (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      sh  <= '0;
    end else if (accept) begin
      if (last) begin
        cnt <= '0;
        sh  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        sh  <= nxt;
      end
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Synchronous program memory with a registered fetch port and a byte-stream
// loader that writes whole instructions sequentially from address 0.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int                     ADDR_WIDTH     = 16,
  parameter int                     INSTR_WIDTH    = PKG_INSTR_WIDTH,
  parameter int                     DEPTH          = 256,
  parameter int                     BYTES_PER_WORD = bytes_per_word(INSTR_WIDTH),
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR      = INSTR_WIDTH'(PKG_NOP_INSTR),
  parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR  = INSTR_WIDTH'(PKG_DEFAULT_INSTR)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [ADDR_WIDTH-1:0]  iAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  input  logic                   iLoadStart,
  input  logic                   iLoadEnd,
  input  logic [7:0]             iLoadByte,
  input  logic                   iLoadValid,
  output logic                   oLoadReady,
  output logic                   oLoadBusy,
  output logic [ADDR_WIDTH:0]    oLoadCount,
  output logic                   oLoadError,
  output load_state_e            oDebugState
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a byte moves on any rising edge where iLoadValid && oLoadReady;
  // while valid is high and ready low the source holds iLoadByte steady.

  load_state_e            state, state_next;
  logic [CW-1:0]          count;
  logic                   error;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic                   busy, ready, xfer, ending;
  logic                   asm_accept, asm_clear;
  logic [INSTR_WIDTH-1:0] asm_word;
  logic                   word_done, pending;
  logic                   err_full, err_partial;
  logic                   in_range;

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (iLoadStart) state_next = S_LOAD;
      S_LOAD: if (!iLoadStart && iLoadEnd) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The write pointer and the completed-word count are the same quantity.
  assign busy        = (state == S_LOAD);
  assign ready       = busy && (count < CW'(DEPTH));
  assign xfer        = iLoadValid && ready;
  assign ending      = busy && iLoadEnd && !iLoadStart;
  assign asm_accept  = xfer && !iLoadStart;
  assign asm_clear   = iLoadStart || ending;
  assign err_full    = busy && iLoadValid && !ready && !iLoadStart;
  assign err_partial = ending && (pending || asm_accept) && !word_done;
  assign in_range    = ({1'b0, iAddress} < CW'(DEPTH));

  prog_mem_loader_byte_word_assembler #(
    .INSTR_WIDTH   (INSTR_WIDTH),
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_asm (
    .clk      (Clock),
    .rst      (Reset),
    .clear    (asm_clear),
    .accept   (asm_accept),
    .data     (iLoadByte),
    .word     (asm_word),
    .word_done(word_done),
    .pending  (pending)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      count        <= '0;
      error        <= 1'b0;
      oInstruction <= NOP_INSTR;
    end else begin
      state <= state_next;
      if (iLoadStart)     count <= '0;
      else if (word_done) count <= count + CW'(1);
      if (iLoadStart)                    error <= 1'b0;
      else if (err_full || err_partial)  error <= 1'b1;
      if (busy)          oInstruction <= NOP_INSTR;
      else if (!in_range) oInstruction <= DEFAULT_INSTR;
      else               oInstruction <= mem[iAddress[IDX_W-1:0]];
    end
  end

  // Memory contents deliberately survive Reset.
  always_ff @(posedge Clock) begin
    if (word_done) mem[count[IDX_W-1:0]] <= asm_word;
  end

  assign oLoadReady  = ready;
  assign oLoadBusy   = busy;
  assign oLoadCount  = count;
  assign oLoadError  = error;
  assign oDebugState = state;

endmodule
